// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, load-op bit positions,
// exception codes and the packed layouts of the EX->MEM and MEM->WB buses.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 159;
  localparam int MS_TO_WS_BUS_WD = 119;
  localparam int LD_OP_WD        = 7;

  // One-hot positions inside ld_op
  localparam int LD_LB  = 0;
  localparam int LD_LBU = 1;
  localparam int LD_LH  = 2;
  localparam int LD_LHU = 3;
  localparam int LD_LW  = 4;
  localparam int LD_LWL = 5;
  localparam int LD_LWR = 6;

  // MIPS ExcCode values; NO_EX is an out-of-band marker for "no exception"
  localparam logic [4:0] EX_INT   = 5'h00;
  localparam logic [4:0] EX_MOD   = 5'h01;
  localparam logic [4:0] EX_TLBL  = 5'h02;
  localparam logic [4:0] EX_TLBS  = 5'h03;
  localparam logic [4:0] EX_ADEL  = 5'h04;
  localparam logic [4:0] EX_ADES  = 5'h05;
  localparam logic [4:0] EX_SYS   = 5'h08;
  localparam logic [4:0] EX_BP    = 5'h09;
  localparam logic [4:0] EX_RI    = 5'h0a;
  localparam logic [4:0] EX_OV    = 5'h0c;
  localparam logic [4:0] EX_NO_EX = 5'h1f;

  typedef struct packed {
    logic [4:0]  rd;
    logic        tlbr;
    logic        tlbwi;
    logic        mfc0;
    logic        mtc0;
    logic        pc_error;
    logic [31:0] badvaddr;
    logic [4:0]  ex_code;
    logic        eret;
    logic        slot;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_ws_t;

  typedef struct packed {
    logic                data_req;
    logic [31:0]         rt_val;
    logic [LD_OP_WD-1:0] ld_op;
    ms_ws_t              ws;
  } es_ms_t;

  function automatic logic [31:0] extend8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] extend16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extraction: picks the addressed byte/half/word out of the
// response word and merges unaligned lwl/lwr data with the old rt value.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [LD_OP_WD-1:0] i_ldOp,
  input  logic [1:0]          i_addrLo,
  input  logic [31:0]         i_rdata,
  input  logic [31:0]         i_rtVal,
  input  logic [31:0]         i_passVal,
  output logic [31:0]         o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_lwl;
  logic [31:0] w_lwr;

  assign w_byte = i_rdata[{i_addrLo, 3'b000} +: 8];
  assign w_half = i_addrLo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // lwl fills the high end of rt from memory, lwr fills the low end
  always_comb begin
    w_lwl = i_rdata;
    w_lwr = i_rdata;
    case (i_addrLo)
      2'd0: begin
        w_lwl = {i_rdata[7:0], i_rtVal[23:0]};
        w_lwr = i_rdata;
      end
      2'd1: begin
        w_lwl = {i_rdata[15:0], i_rtVal[15:0]};
        w_lwr = {i_rtVal[31:24], i_rdata[31:8]};
      end
      2'd2: begin
        w_lwl = {i_rdata[23:0], i_rtVal[7:0]};
        w_lwr = {i_rtVal[31:16], i_rdata[31:16]};
      end
      default: begin
        w_lwl = i_rdata;
        w_lwr = {i_rtVal[31:8], i_rdata[31:24]};
      end
    endcase
  end

  always_comb begin
    o_result = i_passVal;
    if (i_ldOp[LD_LB])       o_result = extend8(w_byte, 1'b1);
    else if (i_ldOp[LD_LBU]) o_result = extend8(w_byte, 1'b0);
    else if (i_ldOp[LD_LH])  o_result = extend16(w_half, 1'b1);
    else if (i_ldOp[LD_LHU]) o_result = extend16(w_half, 1'b0);
    else if (i_ldOp[LD_LW])  o_result = i_rdata;
    else if (i_ldOp[LD_LWL]) o_result = w_lwl;
    else if (i_ldOp[LD_LWR]) o_result = w_lwr;
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response, aligns loads, buffers
// responses WB cannot take yet, and swallows responses of flushed requests.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ws_flush,
  output logic [4:0]                 MS_dest,
  output logic [31:0]                MS_dest_data,
  output logic                       ms_fwd_ok,
  output logic                       MS_EX
);

  logic        r_msValid;
  es_ms_t      r_bus;
  logic [1:0]  r_cancelCnt;
  logic        r_bufValid;
  logic [31:0] r_bufRdata;

  logic        w_dataReq;
  logic        w_hasEx;
  logic        w_okLive;
  logic        w_readyGo;
  logic        w_accept;
  logic        w_bufCapture;
  logic        w_cancelInc;
  logic        w_cancelDec;
  logic [31:0] w_rdata;
  logic [31:0] w_result;
  logic [LD_OP_WD-1:0] w_ldOp;
  ms_ws_t      w_wsBus;

  assign w_dataReq = r_bus.data_req;
  assign w_hasEx   = (r_bus.ws.ex_code != EX_NO_EX);
  // A response only belongs to us once every cancelled request has drained
  assign w_okLive  = data_sram_data_ok & (r_cancelCnt == 2'd0);
  assign w_readyGo = ~w_dataReq | r_bufValid | w_okLive;

  assign ms_allowin     = ~r_msValid | (w_readyGo & ws_allowin);
  assign ms_to_ws_valid = r_msValid & w_readyGo;
  assign w_accept       = es_to_ms_valid & ms_allowin;

  assign w_bufCapture = w_okLive & r_msValid & w_dataReq & ~r_bufValid
                      & ~ws_allowin & ~ws_flush;
  assign w_cancelInc  = ws_flush & r_msValid & w_dataReq & ~r_bufValid & ~w_okLive;
  assign w_cancelDec  = data_sram_data_ok & (r_cancelCnt != 2'd0);

  assign w_rdata = r_bufValid ? r_bufRdata : data_sram_rdata;
  assign w_ldOp  = r_bus.ld_op & {LD_OP_WD{~w_hasEx}};

  load_align u_loadAlign (
    .i_ldOp    (w_ldOp),
    .i_addrLo  (r_bus.ws.result[1:0]),
    .i_rdata   (w_rdata),
    .i_rtVal   (r_bus.rt_val),
    .i_passVal (r_bus.ws.result),
    .o_result  (w_result)
  );

  always_comb begin
    w_wsBus        = r_bus.ws;
    w_wsBus.result = w_result;
  end

  assign ms_to_ws_bus = w_wsBus;
  assign MS_dest      = (r_msValid & r_bus.ws.gr_we) ? r_bus.ws.dest : 5'd0;
  assign MS_dest_data = w_result;
  assign ms_fwd_ok    = r_msValid & w_readyGo & ~r_bus.ws.mfc0;
  assign MS_EX        = r_msValid & (w_hasEx | r_bus.ws.eret);

  // Stage occupancy and the latched EX bus; a flush empties the stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_msValid          <= 1'b0;
      r_bus              <= '0;
      r_bus.ws.ex_code   <= EX_NO_EX;
    end else begin
      if (ws_flush)        r_msValid <= 1'b0;
      else if (ms_allowin) r_msValid <= es_to_ms_valid;
      if (w_accept)        r_bus     <= es_to_ms_bus;
    end
  end

  // Holds a response that arrived while WB was stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bufValid <= 1'b0;
      r_bufRdata <= 32'd0;
    end else begin
      if (w_accept | ws_flush) r_bufValid <= 1'b0;
      else if (w_bufCapture)   r_bufValid <= 1'b1;
      if (w_bufCapture)        r_bufRdata <= data_sram_rdata;
    end
  end

  // Counts responses still owed to flushed requests; saturates at 3
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cancelCnt <= 2'd0;
    end else if (w_cancelInc & ~w_cancelDec) begin
      if (r_cancelCnt != 2'd3) r_cancelCnt <= r_cancelCnt + 2'd1;
    end else if (w_cancelDec & ~w_cancelInc) begin
      r_cancelCnt <= r_cancelCnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scenario-based bench for mem_stage: expected MEM->WB buses go into a queue at
// issue time and are popped when the stage hands an instruction to WB.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [158:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [118:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         ws_flush;
  logic [4:0]   MS_dest;
  logic [31:0]  MS_dest_data;
  logic         ms_fwd_ok;
  logic         MS_EX;

  int total = 0;
  int bad   = 0;
  logic [118:0] sb[$];
  logic [118:0] exp;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_flush          (ws_flush),
    .MS_dest           (MS_dest),
    .MS_dest_data      (MS_dest_data),
    .ms_fwd_ok         (ms_fwd_ok),
    .MS_EX             (MS_EX)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [118:0] ws_fields(input logic [4:0] dest, input logic [31:0] res,
                                             input logic [4:0] exc, input logic [31:0] badv,
                                             input logic mfc0);
    return {5'd7, 1'b0, 1'b0, mfc0, 1'b0, 1'b0, badv, exc, 1'b0, 1'b0, 1'b1, dest, res,
            32'hBFC0_0000 + {25'd0, dest, 2'b00}};
  endfunction

  function automatic logic [158:0] make_es(input logic dreq, input logic [31:0] rt,
                                           input logic [6:0] op, input logic [118:0] ws);
    return {dreq, rt, op, ws};
  endfunction

  function automatic logic [118:0] with_result(input logic [118:0] ws, input logic [31:0] r);
    logic [118:0] t;
    t = ws;
    t[63:32] = r;
    return t;
  endfunction

  function automatic logic [31:0] ref_load(input int op, input logic [1:0] a,
                                           input logic [31:0] d, input logic [31:0] rt);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (op)
      LD_LB:  return {{24{b[7]}}, b};
      LD_LBU: return {24'd0, b};
      LD_LH:  return {{16{h[15]}}, h};
      LD_LHU: return {16'd0, h};
      LD_LW:  return d;
      LD_LWL: case (a)
                2'd0: return {d[7:0], rt[23:0]};
                2'd1: return {d[15:0], rt[15:0]};
                2'd2: return {d[23:0], rt[7:0]};
                default: return d;
              endcase
      default: case (a)
                2'd0: return d;
                2'd1: return {rt[31:24], d[31:8]};
                2'd2: return {rt[31:16], d[31:16]};
                default: return {rt[31:8], d[31:24]};
              endcase
    endcase
  endfunction

  task automatic enter(input logic [158:0] bus);
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus;
    @(negedge clk);
    es_to_ms_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; ws_flush = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("[TB] FAIL reset_allowin: got %b want 1", ms_allowin); end
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", ms_to_ws_valid); end
    total++; if (MS_dest !== 5'd0) begin bad++; $display("[TB] FAIL reset_dest: got %h want 0", MS_dest); end
    total++; if (MS_dest_data !== 32'd0) begin bad++; $display("[TB] FAIL reset_dest_data: got %h want 0", MS_dest_data); end
    total++; if ({ms_fwd_ok, MS_EX} !== 2'b00) begin bad++; $display("[TB] FAIL reset_fwd_ex: got %b want 00", {ms_fwd_ok, MS_EX}); end
    total++; if (ms_to_ws_bus[76:72] !== EX_NO_EX) begin bad++; $display("[TB] FAIL reset_excode: got %h want %h", ms_to_ws_bus[76:72], EX_NO_EX); end
    reset = 1'b0;
  endtask

  task automatic test_load_extract();
    int opT[4];
    logic [1:0]  aT[4];
    logic [31:0] dT[4];
    logic [31:0] rtT[4];
    logic [31:0] eT[4];
    logic [118:0] ws;
    opT = '{LD_LB, LD_LBU, LD_LWL, LD_LWR};
    aT  = '{2'd3, 2'd3, 2'd1, 2'd2};
    dT  = '{32'h80FF1234, 32'h80FF1234, 32'h11223344, 32'h11223344};
    rtT = '{32'h0, 32'h0, 32'hAABBCCDD, 32'hAABBCCDD};
    eT  = '{32'hFFFFFF80, 32'h00000080, 32'h3344CCDD, 32'hAABB1122};
    for (int i = 0; i < 4; i++) begin
      ws = ws_fields(5'd4 + 5'(i), 32'h0000_1000 | {30'd0, aT[i]}, EX_NO_EX, 32'd0, 1'b0);
      sb.push_back(with_result(ws, eT[i]));
      enter(make_es(1'b1, rtT[i], 7'(1 << opT[i]), ws));
      data_sram_data_ok = 1'b1; data_sram_rdata = dT[i];
      #1;
      total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("[TB] FAIL extract_valid[%0d]: got %b want 1", i, ms_to_ws_valid); end
      total++; if (MS_dest_data !== eT[i]) begin bad++; $display("[TB] FAIL extract_fwd[%0d]: got %h want %h", i, MS_dest_data, eT[i]); end
      total++;
      if (sb.size() == 0) begin bad++; $display("[TB] FAIL extract_sb[%0d]: queue empty", i); end
      else begin
        exp = sb.pop_front();
        if (ms_to_ws_bus !== exp) begin bad++; $display("[TB] FAIL extract_bus[%0d]: got %h want %h", i, ms_to_ws_bus, exp); end
      end
      @(negedge clk);
      data_sram_data_ok = 1'b0;
    end
  endtask

  task automatic test_latency();
    logic [118:0] ws;
    ws = ws_fields(5'd9, 32'h0000_2000, EX_NO_EX, 32'd0, 1'b0);
    sb.push_back(with_result(ws, 32'hCAFE_F00D));
    enter(make_es(1'b1, 32'd0, 7'(1 << LD_LW), ws));
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("[TB] FAIL lat_valid_wait[%0d]: got %b want 0", c, ms_to_ws_valid); end
      total++; if (MS_dest !== 5'd9) begin bad++; $display("[TB] FAIL lat_dest[%0d]: got %h want 09", c, MS_dest); end
      total++; if (ms_fwd_ok !== 1'b0) begin bad++; $display("[TB] FAIL lat_fwd_wait[%0d]: got %b want 0", c, ms_fwd_ok); end
    end
    @(negedge clk);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
    #1;
    total++; if ({ms_to_ws_valid, ms_fwd_ok} !== 2'b11) begin bad++; $display("[TB] FAIL lat_done: got %b want 11", {ms_to_ws_valid, ms_fwd_ok}); end
    total++;
    if (sb.size() == 0) begin bad++; $display("[TB] FAIL lat_sb: queue empty"); end
    else begin
      exp = sb.pop_front();
      if (ms_to_ws_bus !== exp) begin bad++; $display("[TB] FAIL lat_bus: got %h want %h", ms_to_ws_bus, exp); end
    end
    @(negedge clk);
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_buffer();
    logic [118:0] ws;
    ws = ws_fields(5'd11, 32'h0000_3002, EX_NO_EX, 32'd0, 1'b0);
    sb.push_back(with_result(ws, 32'hFFFF8001));
    ws_allowin = 1'b0;
    enter(make_es(1'b1, 32'd0, 7'(1 << LD_LH), ws));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80017FFF;
    #1;
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("[TB] FAIL buf_valid_ok: got %b want 1", ms_to_ws_valid); end
    @(negedge clk);
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h12345678;
    #1;
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("[TB] FAIL buf_valid_hold: got %b want 1", ms_to_ws_valid); end
    total++; if (MS_dest_data !== 32'hFFFF8001) begin bad++; $display("[TB] FAIL buf_data_hold: got %h want ffff8001", MS_dest_data); end
    @(negedge clk);
    data_sram_rdata = 32'hDEADBEEF; ws_allowin = 1'b1;
    #1;
    total++;
    if (sb.size() == 0) begin bad++; $display("[TB] FAIL buf_sb: queue empty"); end
    else begin
      exp = sb.pop_front();
      if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp) begin
        bad++; $display("[TB] FAIL buf_bus: got v=%b %h want v=1 %h", ms_to_ws_valid, ms_to_ws_bus, exp);
      end
    end
    @(negedge clk); #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("[TB] FAIL buf_drained: got %b want 0", ms_to_ws_valid); end
  endtask

  task automatic test_flush();
    logic [118:0] ws;
    ws = ws_fields(5'd13, 32'h0000_4000, EX_NO_EX, 32'd0, 1'b0);
    enter(make_es(1'b1, 32'd0, 7'(1 << LD_LW), ws));
    ws_flush = 1'b1;
    @(negedge clk);
    ws_flush = 1'b0;
    #1;
    total++; if ({ms_to_ws_valid, MS_dest} !== 6'd0) begin bad++; $display("[TB] FAIL flush_empty: got v=%b dest=%h want 0", ms_to_ws_valid, MS_dest); end
    ws = ws_fields(5'd14, 32'h0000_4001, EX_NO_EX, 32'd0, 1'b0);
    sb.push_back(with_result(ws, 32'h000000AB));
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = make_es(1'b1, 32'd0, 7'(1 << LD_LBU), ws);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFFFFFF;
    #1;
    total++; if ({ms_to_ws_valid, ms_fwd_ok} !== 2'b00) begin bad++; $display("[TB] FAIL flush_drop: got %b want 00", {ms_to_ws_valid, ms_fwd_ok}); end
    @(negedge clk);
    data_sram_rdata = 32'h0000AB00;
    #1;
    total++;
    if (sb.size() == 0) begin bad++; $display("[TB] FAIL flush_sb: queue empty"); end
    else begin
      exp = sb.pop_front();
      if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp) begin
        bad++; $display("[TB] FAIL flush_next_load: got v=%b %h want v=1 %h", ms_to_ws_valid, ms_to_ws_bus, exp);
      end
    end
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_after: got %b want 0", ms_to_ws_valid); end
  endtask

  task automatic test_exception();
    logic [118:0] ws;
    ws = ws_fields(5'd15, 32'h0000_1003, EX_ADEL, 32'h0000_1003, 1'b0);
    sb.push_back(ws);
    enter(make_es(1'b0, 32'h55555555, 7'(1 << LD_LW), ws));
    data_sram_rdata = 32'h99999999;
    #1;
    total++; if ({ms_to_ws_valid, MS_EX} !== 2'b11) begin bad++; $display("[TB] FAIL ex_valid: got %b want 11", {ms_to_ws_valid, MS_EX}); end
    total++;
    if (sb.size() == 0) begin bad++; $display("[TB] FAIL ex_sb: queue empty"); end
    else begin
      exp = sb.pop_front();
      if (ms_to_ws_bus !== exp) begin bad++; $display("[TB] FAIL ex_bus: got %h want %h", ms_to_ws_bus, exp); end
    end
    @(negedge clk); #1;
    total++; if (MS_EX !== 1'b0) begin bad++; $display("[TB] FAIL ex_clear: got %b want 0", MS_EX); end
  endtask

  task automatic test_back_to_back();
    logic [118:0] ws;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i < 5) begin
        ws = ws_fields(5'd20 + 5'(i), $urandom, EX_NO_EX, 32'd0, 1'b0);
        sb.push_back(ws);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_es(1'b0, $urandom, 7'd0, ws);
      end else begin
        es_to_ms_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("[TB] FAIL b2b_sb[%0d]: queue empty", i); end
        else begin
          exp = sb.pop_front();
          if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp) begin
            bad++; $display("[TB] FAIL b2b_bus[%0d]: got v=%b %h want v=1 %h", i, ms_to_ws_valid, ms_to_ws_bus, exp);
          end
        end
      end
    end
  endtask

  task automatic test_random_loads();
    logic [118:0] ws;
    int op;
    int lat;
    logic [1:0]  a;
    logic [31:0] rt;
    logic [31:0] d;
    logic [31:0] er;
    for (int i = 0; i < 12; i++) begin
      op  = $urandom_range(0, 6);
      lat = $urandom_range(0, 2);
      a   = 2'($urandom);
      rt  = $urandom;
      d   = $urandom;
      er  = ref_load(op, a, d, rt);
      ws  = ws_fields(5'(i + 1), {$urandom_range(0, 32'h0FFF_FFFF), 2'b00} | {30'd0, a}, EX_NO_EX, 32'd0, 1'b0);
      sb.push_back(with_result(ws, er));
      enter(make_es(1'b1, rt, 7'(1 << op), ws));
      for (int c = 0; c < lat; c++) begin
        data_sram_rdata = ~d;
        #1;
        total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("[TB] FAIL rnd_wait[%0d]: got %b want 0", i, ms_to_ws_valid); end
        @(negedge clk);
      end
      data_sram_data_ok = 1'b1; data_sram_rdata = d;
      #1;
      total++;
      if (sb.size() == 0) begin bad++; $display("[TB] FAIL rnd_sb[%0d]: queue empty", i); end
      else begin
        exp = sb.pop_front();
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp) begin
          bad++; $display("[TB] FAIL rnd_bus[%0d] op=%0d a=%0d: got v=%b %h want v=1 %h", i, op, a, ms_to_ws_valid, ms_to_ws_bus, exp);
        end
      end
      @(negedge clk);
      data_sram_data_ok = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_load_extract();
    test_latency();
    test_buffer();
    test_flush();
    test_exception();
    test_back_to_back();
    test_random_loads();
    total++;
    if (sb.size() != 0) begin bad++; $display("[TB] FAIL sb_leftover: got %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
